// File: rtl/cpu_clk_pkg.sv
// Shared encodings for the CPU clock-enable controller.
package cpu_clk_pkg;

  localparam int unsigned MODE_W = 2;

  // Operating mode selected by the board switches
  localparam logic [MODE_W-1:0] MODE_STEP  = 2'b00;
  localparam logic [MODE_W-1:0] MODE_RUN   = 2'b01;
  localparam logic [MODE_W-1:0] MODE_BURST = 2'b10;
  localparam logic [MODE_W-1:0] MODE_HOLD  = 2'b11;

  // Controller state
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    BURST  = 2'd2,
    HALTED = 2'd3
  } state_e;

  // True while the controller is producing enables on its own
  function automatic logic state_is_busy(input state_e s);
    return (s == RUN) || (s == BURST);
  endfunction

endpackage

// File: rtl/cpu_clk_ctrl_btn_debounce.sv
// Push-button conditioning: synchroniser, debounce counter and press pulse.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned SYNC_STAGES     = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_i,
  output logic level_o,
  output logic rise_o
);

  localparam int unsigned CNT_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   rise_q, rise_d;
  logic                   sample_c;

  assign sample_c = sync_q[SYNC_STAGES-1];

  // Metastability synchroniser on the raw button
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], btn_i};
    end
  end

  // Accept a new level only after it has been stable long enough
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    if (sample_c != level_q) begin
      if (cnt_q == CNT_MAX) begin
        level_d = sample_c;
        cnt_d   = '0;
        rise_d  = sample_c;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_d = '0;
    end
  end

  // Debounce state registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;

endmodule

// File: rtl/cpu_clk_ctrl.sv
// CPU clock-enable generator: single-step, divided free-run and fixed bursts.
module cpu_clk_ctrl
  import cpu_clk_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned DIV_WIDTH       = 24,
  parameter int unsigned BURST_WIDTH     = 8,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned CNT_WIDTH       = 16
) (
  input  logic                   sys_clk,
  input  logic                   reset,
  input  logic                   step_btn,
  input  logic [MODE_W-1:0]      mode,
  input  logic [DIV_WIDTH-1:0]   div_limit,
  input  logic [BURST_WIDTH-1:0] burst_len,
  input  logic                   halt,
  output logic                   cpu_clk_en,
  output logic [CNT_WIDTH-1:0]   tick_count,
  output logic                   busy,
  output logic                   halted
);

  state_e                 state_q, state_d;
  logic [DIV_WIDTH-1:0]   div_q, div_d;
  logic [BURST_WIDTH-1:0] burst_q, burst_d;
  logic [CNT_WIDTH-1:0]   tick_q, tick_d;
  logic                   en_q, en_d;
  logic                   busy_q, halted_q;
  logic                   btn_level, btn_rise;
  logic                   press_c, div_hit_c, div_over_c;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .SYNC_STAGES    (SYNC_STAGES)
  ) u_btn (
    .clk_i  (sys_clk),
    .rst_ni (reset),
    .btn_i  (step_btn),
    .level_o(btn_level),
    .rise_o (btn_rise)
  );

  // A press is the debounced 0->1 edge; level is high whenever rise fires
  assign press_c    = btn_rise & btn_level;
  assign div_hit_c  = (div_q == div_limit);
  assign div_over_c = (div_q > div_limit);

  // Next-state, divider, burst and enable decisions
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    burst_d = burst_q;
    en_d    = 1'b0;

    if (halt) begin
      state_d = HALTED;
      div_d   = '0;
      burst_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          case (mode)
            MODE_STEP: begin
              en_d = press_c;
            end
            MODE_RUN: begin
              state_d = RUN;
              div_d   = '0;
            end
            MODE_BURST: begin
              if (press_c && (burst_len != '0)) begin
                state_d = BURST;
                burst_d = burst_len;
                div_d   = '0;
              end
            end
            default: begin
            end
          endcase
        end

        RUN: begin
          if (mode != MODE_RUN) begin
            state_d = IDLE;
            div_d   = '0;
          end else if (div_hit_c) begin
            en_d  = 1'b1;
            div_d = '0;
          end else if (div_over_c) begin
            div_d = '0;
          end else begin
            div_d = div_q + DIV_WIDTH'(1);
          end
        end

        BURST: begin
          if (mode != MODE_BURST) begin
            state_d = IDLE;
            div_d   = '0;
            burst_d = '0;
          end else if (burst_q == '0) begin
            state_d = IDLE;
            div_d   = '0;
          end else if (div_hit_c) begin
            en_d    = 1'b1;
            div_d   = '0;
            burst_d = burst_q - BURST_WIDTH'(1);
          end else if (div_over_c) begin
            div_d = '0;
          end else begin
            div_d = div_q + DIV_WIDTH'(1);
          end
        end

        HALTED: begin
          if (mode == MODE_HOLD) begin
            state_d = IDLE;
          end
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end

    tick_d = en_d ? (tick_q + CNT_WIDTH'(1)) : tick_q;
  end

  // State and output registers
  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      div_q    <= '0;
      burst_q  <= '0;
      tick_q   <= '0;
      en_q     <= 1'b0;
      busy_q   <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      burst_q  <= burst_d;
      tick_q   <= tick_d;
      en_q     <= en_d;
      busy_q   <= state_is_busy(state_d);
      halted_q <= (state_d == HALTED);
    end
  end

  assign cpu_clk_en = en_q;
  assign tick_count = tick_q;
  assign busy       = busy_q;
  assign halted     = halted_q;

endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// Directed bench for cpu_clk_ctrl with a short debounce window.
module tb_cpu_clk_ctrl;
  import cpu_clk_pkg::*;

  localparam int unsigned DEB   = 4;
  localparam int unsigned SYNC  = 2;
  localparam int unsigned DIVW  = 8;
  localparam int unsigned BURW  = 8;
  localparam int unsigned CNTW  = 4;

  logic            sys_clk;
  logic            reset;
  logic            step_btn;
  logic [1:0]      mode;
  logic [DIVW-1:0] div_limit;
  logic [BURW-1:0] burst_len;
  logic            halt;
  logic            cpu_clk_en;
  logic [CNTW-1:0] tick_count;
  logic            busy;
  logic            halted;

  int n_vec;
  int n_err;

  cpu_clk_ctrl #(
    .DEBOUNCE_CYCLES(DEB),
    .DIV_WIDTH      (DIVW),
    .BURST_WIDTH    (BURW),
    .SYNC_STAGES    (SYNC),
    .CNT_WIDTH      (CNTW)
  ) dut (
    .sys_clk   (sys_clk),
    .reset     (reset),
    .step_btn  (step_btn),
    .mode      (mode),
    .div_limit (div_limit),
    .burst_len (burst_len),
    .halt      (halt),
    .cpu_clk_en(cpu_clk_en),
    .tick_count(tick_count),
    .busy      (busy),
    .halted    (halted)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // Compare one observed value against its expectation
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just after the edge
  task automatic cyc();
    @(posedge sys_clk);
    #1;
  endtask

  // Apply reset, check cleared outputs, release
  task automatic do_reset(input string tag);
    reset     = 1'b0;
    step_btn  = 1'b0;
    mode      = MODE_HOLD;
    div_limit = '0;
    burst_len = '0;
    halt      = 1'b0;
    #1;
    chk({tag, "_en"},     32'(cpu_clk_en), 0);
    chk({tag, "_tick"},   32'(tick_count), 0);
    chk({tag, "_busy"},   32'(busy),       0);
    chk({tag, "_halted"}, 32'(halted),     0);
    repeat (2) @(negedge sys_clk);
    reset = 1'b1;
    cyc();
  endtask

  initial begin
    int n;
    int first;
    int last;
    int gaps;
    int seen;
    n_vec = 0;
    n_err = 0;

    // Single step: one enable exactly SYNC+DEB+1 cycles after the edge
    do_reset("rst0");
    mode = MODE_STEP;
    step_btn = 1'b1;
    n = 0; first = 0;
    for (int i = 1; i <= 20; i++) begin
      cyc();
      if (cpu_clk_en) begin
        n++;
        if (first == 0) first = i;
      end
    end
    chk("step_cnt",  32'(n), 1);
    chk("step_lat",  32'(first), 7);
    chk("step_tick", 32'(tick_count), 1);

    // Bouncy button: only the stable level is accepted
    do_reset("rst1");
    mode = MODE_STEP;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      step_btn = (((i / 2) % 2) == 0);
      cyc();
      if (cpu_clk_en) n++;
    end
    step_btn = 1'b1;
    for (int i = 0; i < 30; i++) begin
      cyc();
      if (cpu_clk_en) n++;
    end
    chk("bounce_cnt", 32'(n), 1);
    step_btn = 1'b0;
    repeat (12) cyc();
    step_btn = 1'b1;
    repeat (15) cyc();
    chk("bounce_tick", 32'(tick_count), 2);

    // Free-run with divide-by-4, then divide-by-1
    do_reset("rst2");
    div_limit = 8'd3;
    mode = MODE_RUN;
    seen = 0;
    for (int i = 0; i < 20 && seen == 0; i++) begin
      cyc();
      if (cpu_clk_en) seen = 1;
    end
    chk("run_start", 32'(seen), 1);
    n = 1; gaps = 0;
    for (int k = 1; k < 40; k++) begin
      cyc();
      if (cpu_clk_en) n++;
      if (cpu_clk_en != ((k % 4) == 0)) gaps++;
    end
    chk("run_cnt",  32'(n), 10);
    chk("run_gap",  32'(gaps), 0);
    chk("run_busy", 32'(busy), 1);
    chk("run_tick", 32'(tick_count), 10);
    div_limit = 8'd0;
    repeat (3) cyc();
    n = 0;
    for (int i = 0; i < 8; i++) begin
      cyc();
      if (cpu_clk_en) n++;
    end
    chk("run_div0", 32'(n), 8);

    // Halt beats a coincident pulse and holds until mode=HOLD
    halt = 1'b1;
    cyc();
    chk("halt_en",   32'(cpu_clk_en), 0);
    chk("halt_flag", 32'(halted), 1);
    chk("halt_busy", 32'(busy), 0);
    halt = 1'b0;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      cyc();
      if (cpu_clk_en) n++;
    end
    chk("halt_quiet", 32'(n), 0);
    chk("halt_stay",  32'(halted), 1);
    mode = MODE_HOLD;
    cyc();
    chk("halt_exit", 32'(halted), 0);
    mode = MODE_RUN;
    n = 0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      if (cpu_clk_en) n++;
    end
    chk("halt_resume", 32'(n), 3);

    // Burst of 5 at divide-by-2
    do_reset("rst3");
    mode = MODE_BURST;
    burst_len = 8'd5;
    div_limit = 8'd1;
    step_btn = 1'b1;
    n = 0; first = 0; last = 0; seen = 0;
    for (int i = 1; i <= 30; i++) begin
      cyc();
      if (i == 10) seen = int'(busy);
      if (cpu_clk_en) begin
        n++;
        if (first == 0) first = i;
        last = i;
      end
    end
    chk("burst_cnt",   32'(n), 5);
    chk("burst_first", 32'(first), 9);
    chk("burst_last",  32'(last), 17);
    chk("burst_busy",  32'(seen), 1);
    chk("burst_idle",  32'(busy), 0);
    chk("burst_tick",  32'(tick_count), 5);

    // A press in the middle of a burst adds no pulses
    step_btn = 1'b0;
    repeat (12) cyc();
    div_limit = 8'd3;
    step_btn = 1'b1;
    n = 0;
    for (int i = 1; i <= 45; i++) begin
      cyc();
      if (i == 8) step_btn = 1'b0;
      if (i == 15) step_btn = 1'b1;
      if (cpu_clk_en) n++;
    end
    chk("burst_mid_cnt",  32'(n), 5);
    chk("burst_mid_tick", 32'(tick_count), 10);
    chk("burst_mid_idle", 32'(busy), 0);

    // Zero-length burst produces nothing
    step_btn = 1'b0;
    repeat (12) cyc();
    burst_len = 8'd0;
    step_btn = 1'b1;
    n = 0; seen = 0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (cpu_clk_en) n++;
      if (busy) seen = 1;
    end
    chk("burst0_cnt",  32'(n), 0);
    chk("burst0_busy", 32'(seen), 0);

    // Asynchronous reset in the middle of a burst
    step_btn = 1'b0;
    repeat (12) cyc();
    burst_len = 8'd5;
    div_limit = 8'd1;
    step_btn = 1'b1;
    repeat (12) cyc();
    chk("pre_rst_busy", 32'(busy), 1);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_en",     32'(cpu_clk_en), 0);
    chk("arst_busy",   32'(busy), 0);
    chk("arst_tick",   32'(tick_count), 0);
    chk("arst_halted", 32'(halted), 0);
    step_btn = 1'b0;
    @(negedge sys_clk);
    reset = 1'b1;
    cyc();

    // Tick counter wraps after 17 pulses with a 4-bit counter
    mode = MODE_RUN;
    div_limit = 8'd0;
    n = 0;
    for (int i = 0; i < 60 && n < 17; i++) begin
      cyc();
      if (cpu_clk_en) n++;
    end
    mode = MODE_HOLD;
    chk("wrap_seen", 32'(n), 17);
    cyc();
    chk("wrap_no_extra", 32'(cpu_clk_en), 0);
    chk("wrap_tick",     32'(tick_count), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Guard against a stalled run
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/cpu_clk_ctrl.md
Name: cpu_clk_ctrl

Overview:
Generates the CPU clock-enable for the multi-cycle CPU from sys_clk. It replaces the raw cpuclk_i button and the hard-wired clock path. Supported modes are single-step (debounced button), free-run with a programmable divider, and fixed-length burst. The block sits in top between the board inputs (button, switches) and the CPU/display logic, and honours a halt request from the CPU.

Parameters:
DEBOUNCE_CYCLES, 1000000, consecutive stable samples needed to accept a button level change (≥1).
DIV_WIDTH, 24, width of the free-run/burst divider limit.
BURST_WIDTH, 8, width of the burst length.
SYNC_STAGES, 2, synchroniser flops on step_btn (≥2).
CNT_WIDTH, 16, width of the retired-tick counter.

Ports:
sys_clk  in  1  system clock; the only clock.
reset  in  1  asynchronous, active-low reset.
step_btn  in  1  raw asynchronous push-button (bouncy).
mode  in  2  00 STEP, 01 RUN, 10 BURST, 11 HOLD.
div_limit  in  DIV_WIDTH  enable period minus 1 in RUN/BURST; sampled every cycle.
burst_len  in  BURST_WIDTH  pulses per burst; sampled at burst start.
halt  in  1  CPU halt request (synchronous to sys_clk).
cpu_clk_en  out  1  single-cycle enable; the CPU advances one state per pulse.
tick_count  out  CNT_WIDTH  count of cpu_clk_en pulses; wraps to 0.
busy  out  1  high in RUN or an active BURST.
halted  out  1  high in HALTED.

Behaviour:
- Reset (reset=0, async): all outputs 0, FSM=IDLE, divider=0, burst counter=0, debounced level=0, synchroniser cleared.
- Button path: SYNC_STAGES-flop synchroniser, then debounce counter.
  - The counter increments while the synced sample differs from the debounced level and clears when it matches.
  - When the counter reaches DEBOUNCE_CYCLES-1 with a differing sample, the debounced level flips and the counter clears.
  - A 0→1 debounced transition produces a 1-cycle press pulse.
  - For a clean raw rising edge, cpu_clk_en (STEP) is high exactly SYNC_STAGES+DEBOUNCE_CYCLES+1 cycles after the edge.
- FSM states: IDLE, RUN, BURST, HALTED.
  - IDLE + mode=STEP: each press pulse gives one cpu_clk_en the next cycle. Presses are ignored in other modes.
  - IDLE + mode=RUN → RUN (divider cleared).
  - IDLE + mode=BURST + press → BURST, load burst counter=burst_len, divider cleared. If burst_len=0, stay in IDLE and produce no pulse.
  - RUN: divider counts 0..div_limit. On divider==div_limit it asserts cpu_clk_en and wraps to 0. div_limit=0 gives an enable every cycle. If div_limit drops below the current count, the divider wraps to 0 next cycle with no pulse.
  - BURST: same divider rule. Each pulse decrements the counter; the cycle after the last pulse → IDLE. Presses during BURST are ignored.
  - Any mode change while in RUN/BURST (mode differs from the entering mode) → IDLE next cycle, divider cleared, no pulse that cycle. An in-flight burst is aborted.
  - mode=HOLD: never pulses; a RUN/BURST in progress → IDLE.
  - halt=1 in any state → HALTED next cycle. cpu_clk_en is suppressed in the same cycle halt is high, so halt has priority over a coincident pulse.
  - HALTED: no pulses; exit to IDLE only when mode=HOLD for ≥1 cycle with halt=0. Reset also exits.
- tick_count increments on every cpu_clk_en and wraps from 2^CNT_WIDTH-1 to 0.
- busy = (state==RUN) | (state==BURST). halted = (state==HALTED). Both are registered.
- cpu_clk_en is registered, and never high two consecutive cycles unless div_limit=0 in RUN/BURST.

Decomposition:
- Package cpu_clk_pkg holds:
  - mode encodings: MODE_STEP, MODE_RUN, MODE_BURST, MODE_HOLD;
  - FSM state enum: IDLE, RUN, BURST, HALTED.
- Sub-module btn_debounce holds the synchroniser, the debounce counter and the press pulse. It is parameterised by DEBOUNCE_CYCLES and SYNC_STAGES, and outputs level and rise pulse.

Test Plan (DEBOUNCE_CYCLES=4, SYNC_STAGES=2):
- Step: mode=00, step_btn 0→1 held 20 cycles → exactly one cpu_clk_en, 7 cycles after the edge; tick_count=1.
- Bounce: mode=00, step_btn toggles every 2 cycles for 10 cycles then held high → exactly one pulse after the stable period; release and re-press → tick_count=2.
- Run divider: mode=01, div_limit=3 for 40 cycles → pulses every 4th cycle, 10 pulses, busy=1. Then div_limit=0 → pulse every cycle.
- Burst: mode=10, burst_len=5, div_limit=1, press → 5 pulses 2 cycles apart, then IDLE with busy=0. A second press mid-burst adds nothing. burst_len=0 → no pulse.
- Halt: mode=01, div_limit=0, halt=1 for 1 cycle → no pulse that cycle, halted=1, no pulses in RUN. mode=11 for 1 cycle → halted=0. Back to mode=01 → pulses resume.
- Reset mid-burst and wrap: reset low during BURST → all outputs 0 asynchronously. With CNT_WIDTH=4, 17 pulses → tick_count=1.
